// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the keypad digit-entry block.
//   ROWS / COLS   : keypad geometry (4x4)
//   scan_state_t  : scan FSM states (SCAN, DEBOUNCE, HELD)
//   KEY_MAP       : hex code per [row][col], rows listed top to bottom
//   cnt_width()   : counter width for a count of n, never less than 1 bit
// -----------------------------------------------------------------------------
package keypad_pkg;

   localparam int ROWS = 4;
   localparam int COLS = 4;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } scan_state_t;

   localparam logic [3:0] KEY_MAP [ROWS][COLS] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/display_refresh_mux.sv
// -----------------------------------------------------------------------------
// display_refresh_mux
// Time-multiplexes NUM_DIGITS stored hex digits onto NUM_DIGITS displays.
// Each position stays selected for REFRESH_CYCLES clocks.
//   clk             : system clock
//   reset           : asynchronous, active-low
//   digits_i        : packed digit buffer, position i in bits [4i+3:4i]
//   mask_i          : 1 = position has been written
//   display_sel_o   : one-hot active-high display enable (registered)
//   display_digit_o : digit of the selected position (registered)
//   display_blank_o : 1 = selected position never written (registered)
// -----------------------------------------------------------------------------
module display_refresh_mux
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS     = 2,
   parameter int REFRESH_CYCLES = 19200
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_DIGITS*4-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   mask_i,
   output logic [NUM_DIGITS-1:0]   display_sel_o,
   output logic [3:0]              display_digit_o,
   output logic                    display_blank_o
);

   localparam int RW = cnt_width(REFRESH_CYCLES);
   localparam int IW = cnt_width(NUM_DIGITS);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [RW-1:0]         ref_q, ref_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic [3:0]            digit_q, digit_d;
   logic                  blank_q, blank_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ref_q   <= '0;
         idx_q   <= '0;
         sel_q   <= NUM_DIGITS'(1);
         digit_q <= 4'h0;
         blank_q <= 1'b1;
      end else begin
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         digit_q <= digit_d;
         blank_q <= blank_d;
      end
   end

   always_comb begin
      ref_d = ref_q + RW'(1);
      idx_d = idx_q;
      if (ref_q == REF_LAST) begin
         ref_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
   end

   // Output registers follow idx_q, so the displays change one cycle after idx.
   always_comb begin
      sel_d   = '0;
      digit_d = 4'h0;
      blank_d = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            sel_d[i] = 1'b1;
            digit_d  = digits_i[i*4 +: 4];
            blank_d  = ~mask_i[i];
         end
      end
   end

   assign display_sel_o   = sel_q;
   assign display_digit_o = digit_q;
   assign display_blank_o = blank_q;

endmodule

// File: rtl/keypad_digit_entry.sv
// -----------------------------------------------------------------------------
// keypad_digit_entry
// Scans a 4x4 hex keypad, debounces presses and releases, keeps the last
// NUM_DIGITS accepted keys (digit 0 newest) and refreshes them onto displays.
//   clk           : system clock
//   reset         : asynchronous, active-low
//   keypad_hori   : row inputs, pulled up, 0 = key pressed in driven column
//   keypad_vert   : one-cold column drive
//   key_valid     : one-cycle pulse per accepted press
//   key_code      : code of the last accepted key, held
//   display_sel   : one-hot display enable
//   display_digit : digit of the selected position
//   display_blank : 1 = selected position never written
//   dbg_state     : current scan FSM state
//
// Handshake: key_valid is a single-cycle strobe with no back-pressure; the
// digit buffer captures key_code on every cycle key_valid is high.
// -----------------------------------------------------------------------------
module keypad_digit_entry
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS      = 2,
   parameter int SCAN_SETTLE     = 16,
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter int REFRESH_CYCLES  = 19200
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            keypad_hori,
   output logic [3:0]            keypad_vert,
   output logic                  key_valid,
   output logic [3:0]            key_code,
   output logic [NUM_DIGITS-1:0] display_sel,
   output logic [3:0]            display_digit,
   output logic                  display_blank,
   output logic [1:0]            dbg_state
);

   localparam int SW = cnt_width(SCAN_SETTLE);
   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SCAN_SETTLE - 1);
   localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

   scan_state_t             state_q, state_d;
   logic [1:0]              col_q, col_d;
   logic [1:0]              row_q, row_d;
   logic [SW-1:0]           settle_q, settle_d;
   logic [DW-1:0]           cnt_q, cnt_d;
   logic [3:0]              meta_q, sync_q;
   logic                    key_valid_q, key_valid_d;
   logic [3:0]              key_code_q, key_code_d;
   logic [NUM_DIGITS*4-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;

   logic       row_bit;
   logic       one_low;
   logic [1:0] low_idx;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SCAN;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         settle_q    <= '0;
         cnt_q       <= '0;
         meta_q      <= 4'hF;
         sync_q      <= 4'hF;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         digits_q    <= '0;
         mask_q      <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         settle_q    <= settle_d;
         cnt_q       <= cnt_d;
         meta_q      <= keypad_hori;
         sync_q      <= meta_q;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         if (key_valid_q) begin
            digits_q <= digits_d;
            mask_q   <= mask_d;
         end
      end
   end

   assign row_bit = sync_q[row_q];

   // Only a single low row is a usable press; ghosting/multi-key is skipped.
   always_comb begin
      one_low = 1'b1;
      low_idx = 2'd0;
      case (sync_q)
         4'b1110: low_idx = 2'd0;
         4'b1101: low_idx = 2'd1;
         4'b1011: low_idx = 2'd2;
         4'b0111: low_idx = 2'd3;
         default: one_low = 1'b0;
      endcase
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      settle_d    = settle_q;
      cnt_d       = cnt_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      case (state_q)
         SCAN: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               if (one_low) begin
                  row_d   = low_idx;
                  cnt_d   = '0;
                  state_d = DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         DEBOUNCE: begin
            if (row_bit) begin
               // Bounce: rescan the same column from a fresh settle period.
               state_d  = SCAN;
               settle_d = '0;
               cnt_d    = '0;
            end else if (cnt_q == DEB_LAST) begin
               key_valid_d = 1'b1;
               key_code_d  = KEY_MAP[row_q][col_q];
               cnt_d       = '0;
               state_d     = HELD;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         HELD: begin
            if (!row_bit) begin
               cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d  = SCAN;
               col_d    = col_q + 2'd1;
               settle_d = '0;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         default: begin
            state_d  = SCAN;
            settle_d = '0;
            cnt_d    = '0;
         end
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      keypad_vert = ~(4'b0001 << col_q);
      key_valid   = key_valid_q;
      key_code    = key_code_q;
      dbg_state   = state_q;
   end

   // Shift buffer: newest key enters position 0, oldest falls off the end.
   always_comb begin
      digits_d      = digits_q;
      mask_d        = mask_q;
      digits_d[3:0] = key_code_q;
      mask_d[0]     = 1'b1;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         digits_d[i*4 +: 4] = digits_q[(i-1)*4 +: 4];
         mask_d[i]          = mask_q[i-1];
      end
   end

   display_refresh_mux #(
      .NUM_DIGITS     (NUM_DIGITS),
      .REFRESH_CYCLES (REFRESH_CYCLES)
   ) u_refresh (
      .clk             (clk),
      .reset           (reset),
      .digits_i        (digits_q),
      .mask_i          (mask_q),
      .display_sel_o   (display_sel),
      .display_digit_o (display_digit),
      .display_blank_o (display_blank)
   );

endmodule

// File: tb/tb_keypad_digit_entry.sv
module tb_keypad_digit_entry;
   import keypad_pkg::*;

   localparam int ND = 3;

   logic          clk;
   logic          reset;
   logic [3:0]    keypad_hori;
   logic [3:0]    keypad_vert;
   logic          key_valid;
   logic [3:0]    key_code;
   logic [ND-1:0] display_sel;
   logic [3:0]    display_digit;
   logic          display_blank;
   logic [1:0]    dbg_state;

   logic [15:0]   pressed;   // bit r*4+c = key at row r, column c held down
   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            kv_count = 0;
   logic [3:0]    kv_code = 4'h0;
   int            kv_cyc = 0;
   int            press_cyc;
   int            kv0;

   keypad_digit_entry #(
      .NUM_DIGITS      (ND),
      .SCAN_SETTLE     (4),
      .DEBOUNCE_CYCLES (8),
      .REFRESH_CYCLES  (5)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .keypad_hori   (keypad_hori),
      .keypad_vert   (keypad_vert),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .display_sel   (display_sel),
      .display_digit (display_digit),
      .display_blank (display_blank),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Keypad matrix: a row reads 0 when a pressed key sits in the driven column.
   always_comb begin
      keypad_hori = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !keypad_vert[c]) keypad_hori[r] = 1'b0;
   end

   // Records every key_valid cycle so pulse counts and codes can be checked.
   always @(negedge clk) begin
      if (reset && key_valid) begin
         kv_count <= kv_count + 1;
         kv_code  <= key_code;
         kv_cyc   <= cyc;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [1:0] s, input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (dbg_state == s) found = 1'b1;
      end
      chk(32'(found), 32'd1, tag);
   endtask

   task automatic wait_vert(input logic [3:0] v, input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (keypad_vert == v) found = 1'b1;
      end
      chk(32'(found), 32'd1, tag);
   endtask

   // Watches one full refresh round and checks every position's digit/blank.
   task automatic check_disp(input logic [11:0] e_dig, input logic [2:0] e_vis, input string tag);
      logic [11:0] s_dig;
      logic [2:0]  s_vis;
      logic [2:0]  seen;
      int          bad;
      int          p;
      s_dig = '0; s_vis = '0; seen = '0; bad = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         p = -1;
         case (display_sel)
            3'b001: p = 0;
            3'b010: p = 1;
            3'b100: p = 2;
            default: bad++;
         endcase
         if (p >= 0) begin
            s_dig[p*4 +: 4] = display_digit;
            s_vis[p]        = ~display_blank;
            seen[p]         = 1'b1;
         end
      end
      chk(32'(bad), 32'd0, $sformatf("%s_sel_onehot", tag));
      chk(32'(seen), 32'h7, $sformatf("%s_all_pos", tag));
      chk(32'(s_dig), 32'(e_dig), $sformatf("%s_digits", tag));
      chk(32'(s_vis), 32'(e_vis), $sformatf("%s_unblanked", tag));
   endtask

   // ---------------- driver ----------------
   task automatic press_key(input int r, input int c, input logic [3:0] code, input string tag);
      kv0 = kv_count;
      pressed[r*4+c] = 1'b1;
      repeat (40) @(negedge clk);
      chk(32'(kv_count - kv0), 32'd1, $sformatf("%s_one_kv", tag));
      chk(32'(kv_code), 32'(code), $sformatf("%s_code", tag));
      pressed[r*4+c] = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      pressed = '0;
      reset   = 1'b0;

      // 1: reset values, then the blank refresh walk
      repeat (3) @(negedge clk);
      chk(32'(keypad_vert), 32'hE, "rst_vert");
      chk(32'(key_valid), 32'd0, "rst_kv");
      chk(32'(key_code), 32'd0, "rst_code");
      chk(32'(display_sel), 32'h1, "rst_sel");
      chk(32'(display_digit), 32'd0, "rst_digit");
      chk(32'(display_blank), 32'd1, "rst_blank");
      chk(32'(dbg_state), 32'(SCAN), "rst_state");
      reset = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         chk(32'(display_sel), (k <= 5) ? 32'h1 : (k <= 10) ? 32'h2 : (k <= 15) ? 32'h4 : 32'h1,
             $sformatf("walk_sel_%0d", k));
         chk(32'(display_blank), 32'd1, $sformatf("walk_blank_%0d", k));
      end

      // 2: hold key 6 (row 1, col 2) for 40 cycles, then release
      kv0 = kv_count;
      press_cyc = cyc;
      pressed[1*4+2] = 1'b1;
      repeat (40) @(negedge clk);
      chk(32'(kv_count - kv0), 32'd1, "t2_one_kv");
      chk(32'(kv_code), 32'h6, "t2_code");
      chk(32'((kv_cyc - press_cyc) <= 27), 32'd1, "t2_latency");
      chk(32'(dbg_state), 32'(HELD), "t2_held");
      chk(32'(keypad_vert), 32'hB, "t2_col_frozen");
      pressed = '0;
      repeat (9) @(negedge clk);
      chk(32'(keypad_vert), 32'hB, "t2_still_held");
      @(negedge clk);
      chk(32'(keypad_vert), 32'h7, "t2_next_col3");
      chk(32'(dbg_state), 32'(SCAN), "t2_back_scan");
      check_disp({4'h0, 4'h0, 4'h6}, 3'b001, "t2_disp");

      // 3: short glitch in DEBOUNCE, then a stable press of key 7
      kv0 = kv_count;
      pressed[2*4+0] = 1'b1;
      wait_state(2'(DEBOUNCE), "t3_reach_deb");
      repeat (2) @(negedge clk);
      pressed = '0;
      repeat (3) @(negedge clk);
      chk(32'(dbg_state), 32'(SCAN), "t3_glitch_scan");
      chk(32'(keypad_vert), 32'hE, "t3_same_col");
      repeat (20) @(negedge clk);
      chk(32'(kv_count - kv0), 32'd0, "t3_no_kv");
      press_key(2, 0, 4'h7, "t3_stable");

      // 4: keys 1,2,3,4 -> buffer 4/3/2, the 1 drops out
      press_key(0, 0, 4'h1, "t4_k1");
      check_disp({4'h6, 4'h7, 4'h1}, 3'b111, "t4_mid");
      press_key(0, 1, 4'h2, "t4_k2");
      press_key(0, 2, 4'h3, "t4_k3");
      press_key(1, 0, 4'h4, "t4_k4");
      check_disp({4'h2, 4'h3, 4'h4}, 3'b111, "t4_disp");

      // 5a: two rows low in one column are ignored
      kv0 = kv_count;
      pressed[0*4+1] = 1'b1;
      pressed[2*4+1] = 1'b1;
      repeat (60) @(negedge clk);
      chk(32'(kv_count - kv0), 32'd0, "t5a_no_kv");
      chk(32'(dbg_state), 32'(SCAN), "t5a_scan");
      wait_vert(4'h7, "t5a_cycling");
      pressed = '0;
      repeat (5) @(negedge clk);

      // 5b: keys in different columns -> first scanned wins, other waits
      wait_vert(4'hE, "t5b_col0");
      kv0 = kv_count;
      pressed[0*4+3] = 1'b1;   // A, column 3
      pressed[3*4+1] = 1'b1;   // 0, column 1
      repeat (40) @(negedge clk);
      chk(32'(kv_count - kv0), 32'd1, "t5b_one_kv");
      chk(32'(kv_code), 32'h0, "t5b_first");
      pressed[3*4+1] = 1'b0;
      repeat (40) @(negedge clk);
      chk(32'(kv_count - kv0), 32'd2, "t5b_second_kv");
      chk(32'(kv_code), 32'hA, "t5b_second");
      pressed = '0;
      repeat (20) @(negedge clk);
      check_disp({4'h4, 4'h0, 4'hA}, 3'b111, "t5_disp");

      // 6: asynchronous reset while HELD
      pressed[1*4+1] = 1'b1;
      wait_state(2'(HELD), "t6_reach_held");
      chk(32'(key_code), 32'h5, "t6_code_before");
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk(32'(keypad_vert), 32'hE, "t6_vert");
      chk(32'(dbg_state), 32'(SCAN), "t6_state");
      chk(32'(key_code), 32'd0, "t6_code");
      chk(32'(display_sel), 32'h1, "t6_sel");
      chk(32'(display_digit), 32'd0, "t6_digit");
      chk(32'(display_blank), 32'd1, "t6_blank");
      pressed = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      check_disp({4'h0, 4'h0, 4'h0}, 3'b000, "t6_disp");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
